// File: rtl/riscv_tb_memory_model_if.sv
// Instruction-fetch and load/store handshake bundle between the core and the
// unified memory model. Both ports use req/gnt/valid signalling.
interface riscv_tb_memory_model_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        instr_valid;

  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_byteen;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_valid;

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rdata, instr_err, instr_valid,
    output data_req, data_wr, data_addr, data_wdata, data_byteen,
    input  data_gnt, data_rdata, data_valid
  );

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rdata, instr_err, instr_valid,
    input  data_req, data_wr, data_addr, data_wdata, data_byteen,
    output data_gnt, data_rdata, data_valid
  );
endinterface

// File: rtl/riscv_tb_memory_model.sv
// Unified instruction/data word memory for simulation. Zero-wait-state grants,
// one-cycle registered responses. The array `mem` is preloadable by backdoor
// and is never cleared by reset.
module riscv_tb_memory_model #(
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned AW    = 14
) (
  input  logic                       clk,
  input  logic                       reset_n,
  riscv_tb_memory_model_if.slave     bus
);

  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;

  logic [31:0] mem [0:DEPTH-1];

  logic          instr_in_range;
  logic          data_in_range;
  logic [AW-1:0] instr_idx;
  logic [AW-1:0] data_idx;

  logic        instr_valid_q, instr_valid_d;
  logic        instr_err_q,   instr_err_d;
  logic [31:0] instr_rdata_q, instr_rdata_d;
  logic        data_valid_q,  data_valid_d;
  logic [31:0] data_rdata_q,  data_rdata_d;

  assign instr_in_range = ({1'b0, bus.instr_addr} < BYTE_LIMIT);
  assign data_in_range  = ({1'b0, bus.data_addr}  < BYTE_LIMIT);
  assign instr_idx      = bus.instr_addr[AW+1:2];
  assign data_idx       = bus.data_addr[AW+1:2];

  assign bus.instr_gnt = bus.instr_req & ~reset_n;
  assign bus.data_gnt  = bus.data_req  & ~reset_n;

  // Strobes are masked by reset so a response registered just before reset
  // assertion never becomes visible while reset is held.
  assign bus.instr_valid = instr_valid_q & ~reset_n;
  assign bus.instr_err   = instr_err_q   & ~reset_n;
  assign bus.instr_rdata = instr_rdata_q;
  assign bus.data_valid  = data_valid_q  & ~reset_n;
  assign bus.data_rdata  = data_rdata_q;

  // Next response state: reads sample the array before any same-edge store.
  always_comb begin
    instr_valid_d = bus.instr_gnt;
    instr_err_d   = bus.instr_gnt & ~instr_in_range;
    instr_rdata_d = instr_rdata_q;
    if (bus.instr_gnt) begin
      instr_rdata_d = instr_in_range ? mem[instr_idx] : '0;
    end
    data_valid_d = bus.data_gnt;
    data_rdata_d = data_rdata_q;
    if (bus.data_gnt) begin
      data_rdata_d = (!bus.data_wr && data_in_range) ? mem[data_idx] : '0;
    end
  end

  // Response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      instr_valid_q <= 1'b0;
      instr_err_q   <= 1'b0;
      instr_rdata_q <= '0;
      data_valid_q  <= 1'b0;
      data_rdata_q  <= '0;
    end else begin
      instr_valid_q <= instr_valid_d;
      instr_err_q   <= instr_err_d;
      instr_rdata_q <= instr_rdata_d;
      data_valid_q  <= data_valid_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  // Byte-lane store into the array; out-of-range stores are dropped.
  always_ff @(posedge clk) begin
    if (bus.data_gnt && bus.data_wr && data_in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.data_byteen[i]) begin
          mem[data_idx][8*i +: 8] <= bus.data_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_tb_memory_model.sv
// Scoreboard bench for riscv_tb_memory_model: expected responses are queued
// when a request is granted and compared when the response strobe is due.
module tb_riscv_tb_memory_model;

  localparam logic [31:0] LIMIT = 32'h0001_0000;

  logic clk = 1'b0;
  logic reset_n;

  riscv_tb_memory_model_if bus ();

  riscv_tb_memory_model #(.DEPTH(16384), .AW(14)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } iexp_t;

  iexp_t       iq[$];
  logic [31:0] dq[$];
  logic [31:0] model [int unsigned];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (a >= LIMIT || !model.exists(a >> 2)) return '0;
    return model[a >> 2];
  endfunction

  task automatic set_idle();
    bus.instr_req   = 1'b0;
    bus.instr_addr  = '0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_addr   = '0;
    bus.data_wdata  = '0;
    bus.data_byteen = '0;
  endtask

  task automatic set_fetch(input logic [31:0] a);
    bus.instr_req  = 1'b1;
    bus.instr_addr = a;
  endtask

  task automatic set_data(input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    bus.data_req    = 1'b1;
    bus.data_wr     = wr;
    bus.data_addr   = a;
    bus.data_wdata  = wd;
    bus.data_byteen = be;
  endtask

  // One clock cycle: check grants mid-cycle, update the model, then check
  // the responses just after the edge. Inputs return to idle afterwards.
  task automatic tick(input string tag);
    logic [31:0] w;
    iexp_t       ie;
    @(negedge clk);
    chk({tag, ".ignt"}, 32'(bus.instr_gnt), 32'(bus.instr_req & ~reset_n));
    chk({tag, ".dgnt"}, 32'(bus.data_gnt),  32'(bus.data_req  & ~reset_n));
    if (bus.instr_req && !reset_n) begin
      ie.err   = (bus.instr_addr >= LIMIT);
      ie.rdata = mread(bus.instr_addr);
      iq.push_back(ie);
    end
    if (bus.data_req && !reset_n) begin
      if (bus.data_wr) begin
        dq.push_back('0);
        if (bus.data_addr < LIMIT) begin
          w = mread(bus.data_addr);
          for (int i = 0; i < 4; i++)
            if (bus.data_byteen[i]) w[8*i +: 8] = bus.data_wdata[8*i +: 8];
          model[bus.data_addr >> 2] = w;
        end
      end else begin
        dq.push_back(mread(bus.data_addr));
      end
    end
    @(posedge clk);
    #1;
    if (iq.size() > 0) begin
      ie = iq.pop_front();
      chk({tag, ".ivalid"}, 32'(bus.instr_valid), 32'd1);
      chk({tag, ".ierr"},   32'(bus.instr_err),   32'(ie.err));
      chk({tag, ".irdata"}, bus.instr_rdata,      ie.rdata);
    end else begin
      chk({tag, ".ivalid"}, 32'(bus.instr_valid), 32'd0);
      chk({tag, ".ierr"},   32'(bus.instr_err),   32'd0);
    end
    if (dq.size() > 0) begin
      w = dq.pop_front();
      chk({tag, ".dvalid"}, 32'(bus.data_valid), 32'd1);
      chk({tag, ".drdata"}, bus.data_rdata,      w);
    end else begin
      chk({tag, ".dvalid"}, 32'(bus.data_valid), 32'd0);
    end
    set_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    set_idle();
    reset_n = 1'b1;
    repeat (3) tick("reset");
    chk("reset.irdata0", bus.instr_rdata, 32'd0);
    chk("reset.drdata0", bus.data_rdata,  32'd0);
    reset_n = 1'b0;

    // Preload through the store port.
    set_data(1'b1, 32'h0,   32'h0000_0093, 4'hF); tick("pre0");
    set_data(1'b1, 32'h4,   32'h0010_0113, 4'hF); tick("pre1");
    set_data(1'b1, 32'h200, 32'hAAAA_AAAA, 4'hF); tick("pre2");

    // Back-to-back fetches.
    set_fetch(32'h0); tick("t1.f0");
    set_fetch(32'h4); tick("t1.f4");
    tick("t1.idle");

    // Full-word store then load.
    set_data(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF); tick("t2.st");
    set_data(1'b0, 32'h100, 32'h0, 4'h0);         tick("t2.ld");

    // Partial store, byte lanes 0 and 2.
    set_data(1'b1, 32'h100, 32'h1122_3344, 4'b0101); tick("t3.st");
    set_data(1'b0, 32'h100, 32'h0, 4'h0);            tick("t3.ld");
    chk("t3.value", bus.data_rdata, 32'hDE22_BE44);
    set_data(1'b1, 32'h100, 32'hFFFF_FFFF, 4'b0000); tick("t3.be0");
    set_data(1'b0, 32'h100, 32'h0, 4'h0);            tick("t3.ld2");

    // Out of range: fetch errors, store is dropped, load returns zero.
    set_fetch(LIMIT); tick("t4.fetch");
    set_data(1'b1, LIMIT, 32'hCAFE_F00D, 4'hF); tick("t4.st");
    set_data(1'b0, LIMIT, 32'h0, 4'h0);         tick("t4.ld");
    set_fetch(32'h0); tick("t4.alias");
    set_fetch(32'hFFFF_FFFC); tick("t4.top");

    // Same-cycle fetch and store to one word: fetch sees old data.
    set_fetch(32'h200);
    set_data(1'b1, 32'h200, 32'h5555_5555, 4'hF); tick("t5.rbw");
    set_fetch(32'h200); tick("t5.after");
    set_data(1'b1, 32'h104, 32'h1234_5678, 4'hF); tick("t5.st");
    set_data(1'b0, 32'h104, 32'h0, 4'h0);         tick("t5.ld");

    // Random traffic over a pre-initialised window.
    for (int i = 0; i < 16; i++) begin
      set_data(1'b1, 32'h300 + 32'(i * 4), $urandom, 4'hF);
      tick("rnd.init");
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) set_fetch(32'h300 + 32'($urandom_range(0, 15) * 4));
      if ($urandom_range(0, 3) != 0) begin
        a = 32'h300 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        set_data(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
      tick("rnd");
    end

    // Reset asserted while a load response would be visible: dropped.
    set_data(1'b0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    chk("t6.dgnt", 32'(bus.data_gnt), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_idle();
    #1;
    chk("t6.drop", 32'(bus.data_valid), 32'd0);
    set_fetch(32'h0);
    set_data(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF);
    tick("t6.rst0");
    chk("t6.irdata0", bus.instr_rdata, 32'd0);
    chk("t6.drdata0", bus.data_rdata,  32'd0);
    set_data(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF);
    tick("t6.rst1");
    reset_n = 1'b0;
    tick("t6.rel");
    set_data(1'b0, 32'h100, 32'h0, 4'h0); tick("t6.ld");
    chk("t6.keep", bus.data_rdata, 32'hDE22_BE44);
    set_fetch(32'h0); tick("t6.f0");
    set_fetch(32'h4); tick("t6.f4");
    tick("end");

    chk("sb.iq_empty", 32'(iq.size()), 32'd0);
    chk("sb.dq_empty", 32'(dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
